// File: rtl/fetch_unit.sv
// Decoupled fetch stage: credit-limited request issue, in-order response
// capture into a small instruction queue, and redirect flush with
// discard of responses that were already in flight.
module fetch_unit #(
    parameter int                    ADDR_WIDTH  = 64,
    parameter int                    INSTR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
    parameter int                    QUEUE_DEPTH = 4
) (
    input  logic                   i_clk,
    input  logic                   i_arst,
    input  logic                   i_redirect,
    input  logic [ADDR_WIDTH-1:0]  i_redirect_pc,
    output logic                   o_mem_req_valid,
    input  logic                   i_mem_req_ready,
    output logic [ADDR_WIDTH-1:0]  o_mem_req_addr,
    input  logic                   i_mem_rsp_valid,
    input  logic [INSTR_WIDTH-1:0] i_mem_rsp_data,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic [INSTR_WIDTH-1:0] o_instruction,
    output logic [ADDR_WIDTH-1:0]  o_pc,
    output logic [ADDR_WIDTH-1:0]  o_pc_plus4
);

    localparam int CW = $clog2(QUEUE_DEPTH + 1);
    localparam int PW = $clog2(QUEUE_DEPTH);

    typedef struct packed {
        logic [INSTR_WIDTH-1:0] instr;
        logic [ADDR_WIDTH-1:0]  pc;
    } entry_t;

    entry_t                  q_mem [QUEUE_DEPTH];
    logic [ADDR_WIDTH-1:0]   fetch_pc, rsp_pc, redirect_pc_al;
    logic [PW-1:0]           wr_ptr, rd_ptr;
    logic [CW-1:0]           count, outstanding, drop_cnt;
    logic [CW:0]             credit_sum;
    logic                    req_fire, push, pop;
    entry_t                  head;

    // Issue/accept decisions, all from registered state plus this cycle's inputs
    always_comb begin
        redirect_pc_al  = i_redirect_pc & ~ADDR_WIDTH'(3);
        credit_sum      = {1'b0, outstanding} + {1'b0, count};
        o_mem_req_valid = i_arst && !i_redirect && (credit_sum < (CW+1)'(QUEUE_DEPTH));
        o_mem_req_addr  = fetch_pc;
        req_fire        = o_mem_req_valid && i_mem_req_ready;
        o_valid         = (count != '0) && !i_redirect;
        pop             = o_valid && i_ready;
        push            = i_mem_rsp_valid && (drop_cnt == '0) && !i_redirect;
        head            = q_mem[rd_ptr];
        // Datapath is masked while the queue is empty
        o_instruction   = (count != '0) ? head.instr : '0;
        o_pc            = (count != '0) ? head.pc : '0;
        o_pc_plus4      = (count != '0) ? head.pc + ADDR_WIDTH'(4) : '0;
    end

    // PCs, in-flight and drop accounting
    always_ff @(posedge i_clk or negedge i_arst) begin
        if (!i_arst) begin
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            if (req_fire && !i_mem_rsp_valid)
                outstanding <= outstanding + CW'(1);
            else if (!req_fire && i_mem_rsp_valid && outstanding != '0)
                outstanding <= outstanding - CW'(1);

            if (i_redirect) begin
                fetch_pc <= redirect_pc_al;
                rsp_pc   <= redirect_pc_al;
                // outstanding already covers responses marked for drop, so
                // everything still in flight after this cycle becomes stale;
                // this keeps back-to-back redirects from double counting.
                if (i_mem_rsp_valid && outstanding != '0)
                    drop_cnt <= outstanding - CW'(1);
                else
                    drop_cnt <= outstanding;
            end else begin
                if (req_fire)
                    fetch_pc <= fetch_pc + ADDR_WIDTH'(4);
                if (push)
                    rsp_pc <= rsp_pc + ADDR_WIDTH'(4);
                if (i_mem_rsp_valid && drop_cnt != '0)
                    drop_cnt <= drop_cnt - CW'(1);
            end
        end
    end

    // Queue pointers and occupancy; redirect empties the queue
    always_ff @(posedge i_clk or negedge i_arst) begin
        if (!i_arst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (i_redirect) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            if (push && !pop)
                count <= count + CW'(1);
            else if (!push && pop)
                count <= count - CW'(1);
        end
    end

    // Queue storage write at the tail
    always_ff @(posedge i_clk) begin
        if (push)
            q_mem[wr_ptr] <= '{instr: i_mem_rsp_data, pc: rsp_pc};
    end

    // Protocol checks: no queue overflow, no response without a request
    always_ff @(posedge i_clk) begin
        if (i_arst) begin
            assert (!(push && !pop && count == CW'(QUEUE_DEPTH)));
            assert (!(i_mem_rsp_valid && outstanding == '0));
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a variable-latency memory model and
// a scoreboard of expected instructions keyed by redirect epoch.
module tb_fetch_unit;

    localparam int            AW    = 64;
    localparam int            IW    = 32;
    localparam int            DEPTH = 4;
    localparam logic [AW-1:0] RPC   = 64'h1000;

    logic          i_clk = 1'b0;
    logic          i_arst;
    logic          i_redirect;
    logic [AW-1:0] i_redirect_pc;
    logic          o_mem_req_valid;
    logic          i_mem_req_ready;
    logic [AW-1:0] o_mem_req_addr;
    logic          i_mem_rsp_valid;
    logic [IW-1:0] i_mem_rsp_data;
    logic          o_valid;
    logic          i_ready;
    logic [IW-1:0] o_instruction;
    logic [AW-1:0] o_pc;
    logic [AW-1:0] o_pc_plus4;

    fetch_unit #(.ADDR_WIDTH(AW), .INSTR_WIDTH(IW), .RESET_PC(RPC), .QUEUE_DEPTH(DEPTH)) dut (
        .i_clk(i_clk), .i_arst(i_arst),
        .i_redirect(i_redirect), .i_redirect_pc(i_redirect_pc),
        .o_mem_req_valid(o_mem_req_valid), .i_mem_req_ready(i_mem_req_ready),
        .o_mem_req_addr(o_mem_req_addr),
        .i_mem_rsp_valid(i_mem_rsp_valid), .i_mem_rsp_data(i_mem_rsp_data),
        .o_valid(o_valid), .i_ready(i_ready),
        .o_instruction(o_instruction), .o_pc(o_pc), .o_pc_plus4(o_pc_plus4)
    );

    always #5 i_clk = ~i_clk;

    typedef struct { logic [AW-1:0] addr; int due; int ep; } mreq_t;
    typedef struct { logic [AW-1:0] pc; logic [IW-1:0] ins; } exp_t;

    mreq_t         mq[$];
    exp_t          sq[$];
    int            ncmp = 0, nfail = 0;
    int            cyc = 0, epoch = 0, lat = 1;
    logic [AW-1:0] exp_fetch = RPC;
    logic          drv_redirect = 0, drv_ready = 0, drv_req_ready = 0;
    logic [AW-1:0] drv_rpc = '0;

    function automatic logic [IW-1:0] mem_word(input logic [AW-1:0] a);
        return a[31:0] ^ 32'h5A5A_0000 ^ {a[47:32], 16'h0};
    endfunction

    task automatic chk(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] expv);
        ncmp++;
        assert (obs === expv) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    // One clock: drive inputs at negedge, check outputs 1 time unit later,
    // then advance the memory and scoreboard models for the coming edge.
    task automatic cycle();
        mreq_t m;
        bit    rsp, erv, eov;
        @(negedge i_clk);
        rsp             = (mq.size() > 0) && (mq[0].due <= cyc);
        i_mem_rsp_valid = rsp;
        i_mem_rsp_data  = rsp ? mem_word(mq[0].addr) : '0;
        i_redirect      = drv_redirect;
        i_redirect_pc   = drv_rpc;
        i_ready         = drv_ready;
        i_mem_req_ready = drv_req_ready;
        #1;
        erv = !drv_redirect && (mq.size() + sq.size() < DEPTH);
        eov = (sq.size() != 0) && !drv_redirect;
        chk("req_valid", AW'(o_mem_req_valid), AW'(erv));
        chk("valid", AW'(o_valid), AW'(eov));
        if (erv) chk("req_addr", o_mem_req_addr, exp_fetch);
        if (sq.size() != 0) begin
            chk("pc", o_pc, sq[0].pc);
            chk("pc_plus4", o_pc_plus4, sq[0].pc + 64'd4);
            chk("instr", AW'(o_instruction), AW'(sq[0].ins));
        end else begin
            chk("pc_masked", o_pc, '0);
            chk("instr_masked", AW'(o_instruction), '0);
        end
        if (eov && drv_ready) void'(sq.pop_front());
        if (rsp) begin
            m = mq.pop_front();
            if (m.ep == epoch && !drv_redirect)
                sq.push_back('{m.addr, mem_word(m.addr)});
        end
        if (erv && drv_req_ready) begin
            mq.push_back('{exp_fetch, cyc + lat, epoch});
            exp_fetch = exp_fetch + 64'd4;
        end
        if (drv_redirect) begin
            sq.delete();
            epoch++;
            exp_fetch = drv_rpc & ~64'd3;
        end
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic redirect(input logic [AW-1:0] pc);
        drv_redirect = 1; drv_rpc = pc;
        cycle();
        drv_redirect = 0;
    endtask

    // Assert reset, check masked outputs, clear models, release at negedge
    task automatic apply_reset();
        i_arst = 1'b0;
        i_redirect = 0; i_redirect_pc = '0; i_ready = 0;
        i_mem_req_ready = 0; i_mem_rsp_valid = 0; i_mem_rsp_data = '0;
        mq.delete(); sq.delete();
        exp_fetch = RPC;
        #1;
        chk("rst_req_valid", AW'(o_mem_req_valid), '0);
        chk("rst_valid", AW'(o_valid), '0);
        chk("rst_instr", AW'(o_instruction), '0);
        chk("rst_pc", o_pc, '0);
        chk("rst_pc_plus4", o_pc_plus4, '0);
        @(negedge i_clk);
        i_arst = 1'b1;
    endtask

    // Stop requesting and let everything in flight retire, bounded
    task automatic drain();
        int i;
        drv_req_ready = 0; drv_ready = 1;
        i = 0;
        while (i < 60 && (sq.size() != 0 || mq.size() != 0)) begin
            cycle();
            i++;
        end
        chk("drain_bound", AW'(sq.size() + mq.size()), '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        apply_reset();

        // Streaming with a 1-cycle memory
        lat = 1; drv_ready = 1; drv_req_ready = 1;
        run(12);

        // Decode stall: credit limit stops issue at DEPTH, then drain resumes
        drv_ready = 0;
        run(10);
        drv_ready = 1;
        run(8);

        // Memory not ready: request held with stable address
        drv_req_ready = 0;
        run(5);
        drv_req_ready = 1;
        run(4);

        // Longer latency with requests in flight, redirect to unaligned PC
        lat = 3;
        run(4);
        redirect(64'h2002);
        run(10);

        // Back-to-back redirects; the last one wins
        run(2);
        redirect(64'h3000);
        redirect(64'h4006);
        run(10);

        // Redirect coincident with a response and a dequeue
        lat = 1;
        run(6);
        redirect(64'h5000);
        run(8);

        // Fill to full, then drain with responses arriving alongside pops
        lat = 2; drv_ready = 0;
        run(10);
        drv_ready = 1;
        run(10);

        // Asynchronous reset mid-stream, away from any clock edge
        lat = 1;
        run(3);
        #2;
        apply_reset();
        drv_ready = 1; drv_req_ready = 1;
        run(10);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
